// File: rtl/axis_packet_arbiter.sv
// -----------------------------------------------------------------------------
// axis_packet_arbiter
//
// Shares one AXI-Stream payload input of the Ethernet packet generator
// between NUM_SRC requesters. The arbiter works round-robin and grants whole
// packets. Every outgoing packet is exactly PACKET_PAYLOAD_WORDS beats long.
// A short source packet is zero-padded to that length. A long source packet is
// truncated, and the rest of it is accepted and dropped.
//
// Optional build macro: ARB_STATS_EN. When it is defined, the block adds
// saturating 16-bit counters for packets, padded packets and truncated packets.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   s_axis_tdata       source data; source i uses slice [i*W +: W], W=WORD_BYTES*8
//   s_axis_tvalid      per-source valid
//   s_axis_tlast       per-source last
//   s_axis_tready      per-source ready
//   m_axis_tdata       data to the packet generator
//   m_axis_tvalid      valid to the packet generator
//   m_axis_tlast       last; high on beat PACKET_PAYLOAD_WORDS only
//   m_axis_tready      ready from the packet generator
//   grant_id           source currently granted, or the last one granted
//   busy               high while a packet is in progress (PASS/PAD/DRAIN)
//   pkt_count          (ARB_STATS_EN) master tlast handshakes
//   pad_count          (ARB_STATS_EN) packets that were zero-padded
//   trunc_count        (ARB_STATS_EN) packets that were truncated
// -----------------------------------------------------------------------------
module axis_packet_arbiter #(
    parameter int NUM_SRC              = 4,
    parameter int WORD_BYTES           = 4,
    parameter int PACKET_PAYLOAD_WORDS = 64
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_SRC*WORD_BYTES*8-1:0]     s_axis_tdata,
    input  logic [NUM_SRC-1:0]                  s_axis_tvalid,
    input  logic [NUM_SRC-1:0]                  s_axis_tlast,
    output logic [NUM_SRC-1:0]                  s_axis_tready,
    output logic [WORD_BYTES*8-1:0]             m_axis_tdata,
    output logic                                m_axis_tvalid,
    output logic                                m_axis_tlast,
    input  logic                                m_axis_tready,
    output logic [$clog2(NUM_SRC)-1:0]          grant_id,
    output logic                                busy
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]                         pkt_count,
    output logic [15:0]                         pad_count,
    output logic [15:0]                         trunc_count
`endif
);

    localparam int W  = WORD_BYTES * 8;
    localparam int GW = $clog2(NUM_SRC);
    localparam int BW = $clog2(PACKET_PAYLOAD_WORDS + 1);

    typedef logic [GW:0] sum_t;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS  = 2'd1,
        ST_PAD   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t          r_state;
    logic [BW-1:0]   r_beat_cnt;
    logic [GW-1:0]   r_grant_id;
    logic [GW-1:0]   r_rr_ptr;

    logic [2*NUM_SRC-1:0] w_rot;
    logic                 w_found;
    logic [GW-1:0]        w_off;
    sum_t                 w_sum;
    logic [GW-1:0]        w_winner;
    logic [GW-1:0]        w_next_ptr;
    logic [W-1:0]         w_src_data;
    logic                 w_src_valid;
    logic                 w_src_last;
    logic                 w_last_beat;
    logic                 w_m_hs;

    // Round-robin search: rotate the request vector so rr_ptr sits at bit 0,
    // find the first set bit, then map the offset back to a source index.
    always_comb begin
        w_rot   = {s_axis_tvalid, s_axis_tvalid} >> r_rr_ptr;
        w_found = 1'b0;
        w_off   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!w_found) begin
                if (w_rot[0]) begin
                    w_found = 1'b1;
                end else begin
                    w_off = w_off + 1'b1;
                end
            end else begin
                w_found = 1'b1;
            end
            w_rot = w_rot >> 1;
        end
        w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
        if (w_sum >= sum_t'(NUM_SRC)) begin
            w_winner = GW'(w_sum - sum_t'(NUM_SRC));
        end else begin
            w_winner = GW'(w_sum);
        end
    end

    assign w_next_ptr  = (r_grant_id == GW'(NUM_SRC - 1)) ? '0 : (r_grant_id + 1'b1);
    assign w_src_data  = W'(s_axis_tdata >> (r_grant_id * W));
    assign w_src_valid = s_axis_tvalid[r_grant_id];
    assign w_src_last  = s_axis_tlast[r_grant_id];
    assign w_last_beat = (r_beat_cnt == BW'(PACKET_PAYLOAD_WORDS - 1));
    assign w_m_hs      = m_axis_tvalid & m_axis_tready;

    assign grant_id = r_grant_id;
    assign busy     = (r_state != ST_IDLE);

    // Packet FSM: state, beat counter, grant and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_beat_cnt <= '0;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant_id <= w_winner;
                        r_state    <= ST_PASS;
                    end
                end
                ST_PASS: begin
                    if (w_m_hs) begin
                        if (w_last_beat) begin
                            // A full-length beat without source tlast leaves
                            // the tail of the source packet to be drained.
                            if (w_src_last) begin
                                r_beat_cnt <= '0;
                                r_rr_ptr   <= w_next_ptr;
                                r_state    <= ST_IDLE;
                            end else begin
                                r_beat_cnt <= r_beat_cnt + 1'b1;
                                r_state    <= ST_DRAIN;
                            end
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                            if (w_src_last) begin
                                r_state <= ST_PAD;
                            end
                        end
                    end
                end
                ST_PAD: begin
                    if (w_m_hs) begin
                        if (w_last_beat) begin
                            r_beat_cnt <= '0;
                            r_rr_ptr   <= w_next_ptr;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_src_valid && w_src_last) begin
                        r_beat_cnt <= '0;
                        r_rr_ptr   <= w_next_ptr;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_beat_cnt <= '0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    // Datapath steering: master-side mux and per-source ready decode.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        case (r_state)
            ST_PASS: begin
                m_axis_tdata              = w_src_data;
                m_axis_tvalid             = w_src_valid;
                m_axis_tlast              = w_last_beat;
                s_axis_tready[r_grant_id] = m_axis_tready;
            end
            ST_PAD: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = w_last_beat;
            end
            ST_DRAIN: begin
                s_axis_tready[r_grant_id] = 1'b1;
            end
            default: begin
                m_axis_tvalid = 1'b0;
            end
        endcase
    end

`ifdef ARB_STATS_EN
    logic w_enter_pad;
    logic w_enter_drain;

    assign w_enter_pad   = (r_state == ST_PASS) && w_m_hs && w_src_last && !w_last_beat;
    assign w_enter_drain = (r_state == ST_PASS) && w_m_hs && w_last_beat && !w_src_last;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count   <= 16'd0;
            pad_count   <= 16'd0;
            trunc_count <= 16'd0;
        end else begin
            if (w_m_hs && m_axis_tlast) begin
                pkt_count <= sat_inc(pkt_count);
            end
            if (w_enter_pad) begin
                pad_count <= sat_inc(pad_count);
            end
            if (w_enter_drain) begin
                trunc_count <= sat_inc(trunc_count);
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_packet_arbiter.sv
module tb_axis_packet_arbiter;

    localparam int NS = 4;
    localparam int NW = 4;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } sbeat_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [1:0]  src;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [NS*32-1:0] s_axis_tdata;
    logic [NS-1:0]  s_axis_tvalid;
    logic [NS-1:0]  s_axis_tlast;
    logic [NS-1:0]  s_axis_tready;
    logic [31:0]    m_axis_tdata;
    logic           m_axis_tvalid;
    logic           m_axis_tlast;
    logic           m_axis_tready;
    logic [1:0]     grant_id;
    logic           busy;
`ifdef ARB_STATS_EN
    logic [15:0]    pkt_count;
    logic [15:0]    pad_count;
    logic [15:0]    trunc_count;
`endif

    int compared = 0;
    int mismatched = 0;

    sbeat_t src_q[NS][$];
    exp_t   exp_q[$];
    logic   chk_gap = 1'b0;

    axis_packet_arbiter #(
        .NUM_SRC(NS),
        .WORD_BYTES(4),
        .PACKET_PAYLOAD_WORDS(NW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .grant_id(grant_id),
        .busy(busy)
`ifdef ARB_STATS_EN
        ,
        .pkt_count(pkt_count),
        .pad_count(pad_count),
        .trunc_count(trunc_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic drive_srcs();
        for (int i = 0; i < NS; i++) begin
            if (src_q[i].size() > 0) begin
                s_axis_tvalid[i]          = 1'b1;
                s_axis_tdata[i*32 +: 32]  = src_q[i][0].data;
                s_axis_tlast[i]           = src_q[i][0].last;
            end else begin
                s_axis_tvalid[i]          = 1'b0;
                s_axis_tdata[i*32 +: 32]  = 32'd0;
                s_axis_tlast[i]           = 1'b0;
            end
        end
    endtask

    // One clock: sample source handshakes mid-cycle, advance queues after the edge.
    task automatic cycle();
        logic [NS-1:0] hs;
        @(negedge clk);
        hs = s_axis_tvalid & s_axis_tready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) begin
            if (hs[i] && src_q[i].size() > 0) begin
                void'(src_q[i].pop_front());
            end
        end
        drive_srcs();
    endtask

    task automatic flush();
        for (int i = 0; i < NS; i++) src_q[i].delete();
        exp_q.delete();
        drive_srcs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush();
        cycle();
        rst = 1'b0;
    endtask

    // Source sends n beats base, base+1, ... with tlast on beat n.
    task automatic add_src(input int s, input int n, input logic [31:0] base);
        for (int k = 0; k < n; k++) begin
            src_q[s].push_back('{data: base + 32'(k), last: (k == n - 1)});
        end
        drive_srcs();
    endtask

    // Master view: first NW beats, zero beyond the source packet, tlast on beat NW.
    task automatic add_exp(input int s, input int n, input logic [31:0] base);
        for (int k = 0; k < NW; k++) begin
            exp_q.push_back('{data: (k < n) ? base + 32'(k) : 32'd0,
                              last: (k == NW - 1), src: 2'(s)});
        end
    endtask

    task automatic run_until_empty(input string name, input int limit);
        int n = 0;
        while (exp_q.size() > 0 && n < limit) begin
            cycle();
            n++;
        end
        if (exp_q.size() > 0) begin
            check({name, "_timeout"}, 64'(exp_q.size()), 64'd0);
        end
    endtask

    // Scoreboard monitor.
    initial begin
        logic        seen_last = 1'b0;
        int          gap = 0;
        logic        prev_stall = 1'b0;
        logic [31:0] prev_data = 32'd0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen_last  = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_hold", {31'd0, m_axis_tvalid, m_axis_tdata}, {31'd0, 1'b1, prev_data});
                end
                if (seen_last) begin
                    if (m_axis_tvalid) begin
                        if (chk_gap) check("idle_gap", 64'(gap), 64'd1);
                        seen_last = 1'b0;
                    end else begin
                        gap++;
                    end
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", {29'd0, grant_id, m_axis_tlast, m_axis_tdata}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", {29'd0, grant_id, m_axis_tlast, m_axis_tdata},
                                      {29'd0, e.src, e.last, e.data});
                    end
                    if (m_axis_tlast) begin
                        seen_last = 1'b1;
                        gap = 0;
                    end
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_data  = m_axis_tdata;
            end
        end
    end

    // Stimulus.
    initial begin
        logic pat[4];
        int   n;
        rst           = 1'b1;
        m_axis_tready = 1'b1;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tlast  = '0;
        cycle();
        do_reset();

        // Reset state
        check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_m_tlast",  64'(m_axis_tlast),  64'd0);
        check("rst_m_tdata",  64'(m_axis_tdata),  64'd0);
        check("rst_s_tready", 64'(s_axis_tready), 64'd0);
        check("rst_grant",    64'(grant_id),      64'd0);
        check("rst_busy",     64'(busy),          64'd0);

        // Source 2 alone, exact length
        add_src(2, 4, 32'h11);
        add_exp(2, 4, 32'h11);
        run_until_empty("t1", 40);
        check("t1_grant", 64'(grant_id), 64'd2);
        check("t1_busy_low", 64'(busy), 64'd0);

        // Sources 0, 1, 3 compete from reset
        do_reset();
        chk_gap = 1'b1;
        for (int p = 0; p < 2; p++) begin
            add_src(0, 4, 32'h0000_0100 + 32'(p * 16));
            add_src(1, 4, 32'h0000_1100 + 32'(p * 16));
            add_src(3, 4, 32'h0000_3100 + 32'(p * 16));
        end
        for (int p = 0; p < 2; p++) begin
            add_exp(0, 4, 32'h0000_0100 + 32'(p * 16));
            add_exp(1, 4, 32'h0000_1100 + 32'(p * 16));
            add_exp(3, 4, 32'h0000_3100 + 32'(p * 16));
        end
        run_until_empty("t2", 200);
        chk_gap = 1'b0;

        // Short packet padded
        add_src(1, 2, 32'hA1);
        add_exp(1, 2, 32'hA1);
        run_until_empty("t3", 40);
        check("t3_busy_low", 64'(busy), 64'd0);
`ifdef ARB_STATS_EN
        check("t3_pad_count", 64'(pad_count), 64'd1);
`endif

        // Long packet truncated and drained
        add_src(0, 6, 32'hB1);
        add_exp(0, 6, 32'hB1);
        run_until_empty("t4", 40);
        n = 0;
        while (src_q[0].size() > 0 && n < 20) begin
            cycle();
            n++;
        end
        check("t4_drained", 64'(src_q[0].size()), 64'd0);
        check("t4_busy_low", 64'(busy), 64'd0);
`ifdef ARB_STATS_EN
        check("t4_trunc_count", 64'(trunc_count), 64'd1);
        check("t4_pkt_count",   64'(pkt_count),   64'd8);
`endif

        // Master backpressure mid-packet
        add_src(2, 4, 32'hC1);
        add_exp(2, 4, 32'hC1);
        n = 0;
        while (!m_axis_tvalid && n < 20) begin
            cycle();
            n++;
        end
        check("t5_valid_seen", 64'(m_axis_tvalid), 64'd1);
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            m_axis_tready = pat[k];
            cycle();
        end
        m_axis_tready = 1'b1;
        run_until_empty("t5", 40);

        // Reset mid-packet, then source 3 requests
        add_src(0, 4, 32'hD1);
        add_exp(0, 4, 32'hD1);
        n = 0;
        while (exp_q.size() > 2 && n < 40) begin
            cycle();
            n++;
        end
        check("t6_two_beats", 64'(exp_q.size()), 64'd2);
        do_reset();
        check("t6_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("t6_m_tlast",  64'(m_axis_tlast),  64'd0);
        check("t6_m_tdata",  64'(m_axis_tdata),  64'd0);
        check("t6_s_tready", 64'(s_axis_tready), 64'd0);
        check("t6_busy",     64'(busy),          64'd0);
        check("t6_grant_rst", 64'(grant_id),     64'd0);
        add_src(3, 4, 32'hE1);
        add_exp(3, 4, 32'hE1);
        run_until_empty("t6", 40);
        check("t6_grant", 64'(grant_id), 64'd3);

        repeat (5) cycle();
        check("final_exp_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/axis_packet_arbiter.md
Name: axis_packet_arbiter

Overview:
- Shares the single AXI-Stream payload input of the Ethernet packet generator between NUM_SRC independent requesters, such as counter and telemetry sources.
- Arbitrates round-robin with packet granularity: once a source is granted, its packet passes uninterrupted until the packet completes.
- Normalises every packet to exactly PACKET_PAYLOAD_WORDS beats. Short packets are zero-padded; long packets are truncated and their remainder drained.
- Sits directly upstream of the packet generator's s_axis port.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..8).
- WORD_BYTES, 4, bytes per stream word.
- PACKET_PAYLOAD_WORDS, 64, beats per outgoing packet; must match the downstream generator.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- s_axis_tdata  input  NUM_SRC*WORD_BYTES*8  source data; source i occupies slice [i*W +: W], W=WORD_BYTES*8
- s_axis_tvalid  input  NUM_SRC  per-source valid
- s_axis_tlast  input  NUM_SRC  per-source last
- s_axis_tready  output  NUM_SRC  per-source ready
- m_axis_tdata  output  WORD_BYTES*8  data to the packet generator
- m_axis_tvalid  output  1  valid
- m_axis_tlast  output  1  last; asserted on beat PACKET_PAYLOAD_WORDS only
- m_axis_tready  input  1  ready from the packet generator
- grant_id  output  $clog2(NUM_SRC)  currently or last granted source
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst, synchronous, active-high; clock clk) forces the following:
  - state=IDLE, beat_cnt=0, grant_id=0.
  - rr_ptr=0, so source 0 has highest priority after reset.
  - All outputs low.
  - Reset mid-packet abandons the packet immediately; no tlast is emitted.
- State IDLE:
  - All s_axis_tready=0, m_axis_tvalid=0.
  - If any s_axis_tvalid is high, grant the first valid source searching from rr_ptr upward with wrap-around.
  - Register the winner into grant_id and go to PASS. Arbitration costs 1 cycle.
- State PASS:
  - m_axis_tdata/tvalid are combinationally muxed from the granted source.
  - s_axis_tready[grant_id]=m_axis_tready; all other readies are 0.
  - Each beat handshake on the master side increments beat_cnt.
  - Source tlast on beat beat_cnt+1 == PACKET_PAYLOAD_WORDS: m_axis_tlast=1, then go to IDLE.
  - Source tlast earlier than that: forward the beat with m_axis_tlast=0, then go to PAD.
  - Beat PACKET_PAYLOAD_WORDS without source tlast: assert m_axis_tlast=1, then go to DRAIN.
- State PAD:
  - s_axis_tready all 0.
  - m_axis_tvalid=1, m_axis_tdata=0.
  - Continue until beat PACKET_PAYLOAD_WORDS, which carries m_axis_tlast=1, then go to IDLE.
- State DRAIN:
  - s_axis_tready[grant_id]=1, m_axis_tvalid=0.
  - Discard source beats until a source tlast handshake, then go to IDLE.
- Leaving any state to IDLE:
  - beat_cnt resets to 0.
  - rr_ptr becomes grant_id+1, modulo NUM_SRC.
- Master backpressure:
  - m_axis_tready=0 stalls all counting.
  - tdata/tvalid must remain stable while stalled; the source is held because its ready is 0.
- Simultaneous requests from several sources are resolved strictly by rr_ptr order; a source never wins twice while another source is waiting.
- beat_cnt width is $clog2(PACKET_PAYLOAD_WORDS+1) and it never wraps.
- A source that drops tvalid mid-packet stalls the master stream; no timeout.
- busy=1 in PASS, PAD and DRAIN.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined: adds output ports pkt_count, pad_count and trunc_count, each 16 bits, saturating at 16'hFFFF.
  - pkt_count increments on every master tlast handshake.
  - pad_count increments on entry to PAD.
  - trunc_count increments on entry to DRAIN.
  - All three counters clear on rst.
- Not defined: the ports and counters are absent. Streaming behaviour is identical.

Test Plan:
Bench configuration: NUM_SRC=4, PACKET_PAYLOAD_WORDS=4, WORD_BYTES=4.
- Source 2 alone sends 4 beats 0x11..0x14 with tlast on beat 4 -> master sees the same 4 beats with tlast on beat 4; grant_id=2; busy returns low 1 cycle after the last handshake.
- Sources 0, 1 and 3 all hold valid 4-beat packets continuously from reset -> master packet order is 0, 1, 3, 0, 1, 3; exactly one idle cycle between packets.
- Source 1 sends 2 beats 0xA1, 0xA2 with tlast on beat 2 -> master sees 0xA1, 0xA2, 0, 0 with tlast only on beat 4; pad_count=1 when ARB_STATS_EN is defined.
- Source 0 sends 6 beats 0xB1..0xB6 with tlast on beat 6 -> master sees 0xB1..0xB4 with tlast on 0xB4; 0xB5 and 0xB6 are accepted and dropped; trunc_count=1.
- m_axis_tready toggled 1,0,0,1 during a PASS packet -> no beat lost or duplicated; tdata stable through the stall; m_axis_tlast still on beat 4.
- rst asserted for 1 cycle after the second beat of a packet -> next cycle all outputs are 0 and state is IDLE; a new request from source 3 is granted with grant_id=3.
